// File: rtl/arb_pkg.sv
// Shared types and constants for the N-input priority / round-robin arbiter.
package arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/prio_rr_pick.sv
// Combinational winner select: highest index in fixed mode, first set bit
// at or above ptr (wrapping) in round-robin mode.
module prio_rr_pick
    import arb_pkg::*;
#(
    parameter int N = 8,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             mode,
    output logic [IDX_W-1:0] w,
    output logic             any
);

    int j;

    always_comb begin
        w = '0;
        j = 0;
        if (mode == MODE_FIXED) begin
            for (int i = 0; i < N; i++)
                if (req[i]) w = IDX_W'(i);
        end else begin
            // Walk offsets downward so the offset nearest ptr is written last.
            for (int k = N - 1; k >= 0; k--) begin
                j = int'(ptr) + k;
                if (j >= N) j = j - N;
                if (req[j]) w = IDX_W'(j);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/priority_arbiter_n.sv
// Registered N-input arbiter with request/acknowledge handshake; a grant is
// held until ack, and a new winner can be issued on the ack edge.
module priority_arbiter_n
    import arb_pkg::*;
#(
    parameter int N = 8,
    localparam int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic [N-1:0]     req,
    input  logic             ack,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] ptr_adv;
    logic [IDX_W-1:0] ptr_pick;
    logic [IDX_W-1:0] w;
    logic             any;
    logic             rr_ack;

    assign ptr_adv  = (idx == IDX_W'(N - 1)) ? '0 : idx + IDX_W'(1);
    assign rr_ack   = (state == GRANT) && ack && (mode == MODE_RR);
    // Same-edge re-arbitration must already see the advanced pointer.
    assign ptr_pick = rr_ack ? ptr_adv : ptr;

    prio_rr_pick #(.N(N)) u_pick (
        .req  (req),
        .ptr  (ptr_pick),
        .mode (mode),
        .w    (w),
        .any  (any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            grant <= '0;
            idx   <= '0;
            valid <= 1'b0;
            ptr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any) begin
                        grant <= {{(N-1){1'b0}}, 1'b1} << w;
                        idx   <= w;
                        valid <= 1'b1;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (ack) begin
                        if (rr_ack) ptr <= ptr_adv;
                        if (any) begin
                            grant <= {{(N-1){1'b0}}, 1'b1} << w;
                            idx   <= w;
                        end else begin
                            grant <= '0;
                            valid <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
